// File: rtl/sync_tx.sv
// sync_tx: K/J line frame transmitter: SYNC_LEN SYNC symbols, DATA_W NRZI payload bits (LSB first), EOP.
// Optional feature macro SYNC_TX_BIT_STUFF_EN: insert a stuffed 0 after six consecutive payload ones.
module sync_tx #(
    parameter int unsigned SYNC_LEN = 8,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              k,
    output logic              j,
    output logic              tx_en,
    output logic              busy,
    output logic              done
);

    localparam int unsigned SYM_W = 4;   // SYNC index up to 15, EOP index up to 2
    localparam int unsigned BIT_W = 6;   // payload bits emitted, up to 32

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        EOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SYM_W-1:0]  sym_q, sym_d, sym_nxt;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              k_d, j_d, tx_en_d, busy_d, done_d;
    logic              sync_k;
    logic              stuff;

`ifdef SYNC_TX_BIT_STUFF_EN
    logic [2:0] ones_q, ones_d;
    assign stuff = (ones_q == 3'd6);
`else
    assign stuff = 1'b0;
`endif

    // Next SYNC symbol: K on even indices and always on the last one
    assign sym_nxt = sym_q + SYM_W'(1);
    assign sync_k  = ~sym_nxt[0] | (sym_nxt == SYM_W'(SYNC_LEN - 1));

    // Next-state and next-output logic; outputs are registered from these values
    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        k_d     = k;
        j_d     = j;
        tx_en_d = 1'b1;
        busy_d  = 1'b1;
        done_d  = 1'b0;
`ifdef SYNC_TX_BIT_STUFF_EN
        ones_d  = ones_q;
`endif
        case (state_q)
            IDLE: begin
                k_d     = 1'b0;
                j_d     = 1'b1;
                tx_en_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = SYNC;
                    sym_d   = '0;
                    shreg_d = data_in;
                    k_d     = 1'b1;
                    j_d     = 1'b0;
                    tx_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SYNC: begin
                if (sym_q == SYM_W'(SYNC_LEN - 1)) begin
                    // First payload bit, NRZI relative to the final K
                    state_d = DATA;
                    sym_d   = '0;
                    bit_d   = BIT_W'(1);
                    shreg_d = shreg_q >> 1;
                    k_d     = k ^ ~shreg_q[0];
                    j_d     = j ^ ~shreg_q[0];
`ifdef SYNC_TX_BIT_STUFF_EN
                    ones_d  = shreg_q[0] ? 3'd1 : 3'd0;
`endif
                end else begin
                    sym_d = sym_nxt;
                    k_d   = sync_k;
                    j_d   = ~sync_k;
                end
            end
            DATA: begin
                if (stuff) begin
                    k_d = ~k;
                    j_d = ~j;
`ifdef SYNC_TX_BIT_STUFF_EN
                    ones_d = 3'd0;
`endif
                end else if (bit_q == BIT_W'(DATA_W)) begin
                    state_d = EOP;
                    sym_d   = '0;
                    bit_d   = '0;
                    k_d     = 1'b0;
                    j_d     = 1'b0;
                end else begin
                    bit_d   = bit_q + BIT_W'(1);
                    shreg_d = shreg_q >> 1;
                    k_d     = k ^ ~shreg_q[0];
                    j_d     = j ^ ~shreg_q[0];
`ifdef SYNC_TX_BIT_STUFF_EN
                    ones_d  = shreg_q[0] ? 3'(ones_q + 3'd1) : 3'd0;
`endif
                end
            end
            EOP: begin
                if (sym_q == SYM_W'(0)) begin
                    sym_d = SYM_W'(1);
                    k_d   = 1'b0;
                    j_d   = 1'b0;
                end else if (sym_q == SYM_W'(1)) begin
                    sym_d = SYM_W'(2);
                    k_d   = 1'b0;
                    j_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                    sym_d   = '0;
                    k_d     = 1'b0;
                    j_d     = 1'b1;
                    tx_en_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = 1'b0;
                j_d     = 1'b1;
                tx_en_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and registered line outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            sym_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            k       <= 1'b0;
            j       <= 1'b1;
            tx_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SYNC_TX_BIT_STUFF_EN
            ones_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            k       <= k_d;
            j       <= j_d;
            tx_en   <= tx_en_d;
            busy    <= busy_d;
            done    <= done_d;
`ifdef SYNC_TX_BIT_STUFF_EN
            ones_q  <= ones_d;
`endif
        end
    end

endmodule

// File: tb/tb_sync_tx.sv
// Self-checking bench for sync_tx: vector table, hand sequences and random frames vs a frame-level model.
module tb_sync_tx;

    localparam int unsigned SYNC_LEN = 8;
    localparam int unsigned DATA_W   = 8;
    localparam logic [1:0]  SYM_K    = 2'b10;
    localparam logic [1:0]  SYM_J    = 2'b01;
    localparam logic [1:0]  SYM_SE0  = 2'b00;

    logic              CLK;
    logic              RST;
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              k, j, tx_en, busy, done;

    int n_cmp;
    int n_err;

    logic [1:0] exp_q[$];
    logic [1:0] act_q[$];

    typedef struct {
        logic [7:0]  data;
        int unsigned len;
        logic [1:0]  last;
    } vec_t;

    vec_t tbl[6];

    sync_tx #(.SYNC_LEN(SYNC_LEN), .DATA_W(DATA_W)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .data_in (data_in),
        .k       (k),
        .j       (j),
        .tx_en   (tx_en),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {k,j,tx_en,busy,done}=%b want %b", name, act, exp);
        end
    endtask

    // Expected line symbols of one whole frame, built from the protocol rules
    task automatic build_frame(input logic [7:0] d);
        logic [1:0] line;
        int         ones;
        exp_q.delete();
        for (int i = 0; i < int'(SYNC_LEN); i++)
            exp_q.push_back(((i % 2) == 0 || i == int'(SYNC_LEN) - 1) ? SYM_K : SYM_J);
        line = SYM_K;
        ones = 0;
        for (int b = 0; b < int'(DATA_W); b++) begin
            if (d[b] == 1'b0) line = ~line;
            exp_q.push_back(line);
            ones = d[b] ? ones + 1 : 0;
`ifdef SYNC_TX_BIT_STUFF_EN
            if (ones == 6) begin
                line = ~line;
                exp_q.push_back(line);
                ones = 0;
            end
`endif
        end
        exp_q.push_back(SYM_SE0);
        exp_q.push_back(SYM_SE0);
        exp_q.push_back(SYM_J);
    endtask

    // Called at a negedge with the DUT idle (or in its done cycle); returns at the negedge of the done cycle
    task automatic run_frame(input logic [7:0] d, input int glitch_at, input bit hold);
        build_frame(d);
        act_q.delete();
        start   = 1'b1;
        data_in = d;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge CLK);
            start   = hold;
            data_in = DATA_W'($urandom);
            if (i == glitch_at) begin
                start   = 1'b1;
                data_in = 8'h3C;
            end
            act_q.push_back({k, j});
            check($sformatf("frame_%02h_cyc%0d", d, i), {k, j, tx_en, busy, done}, {exp_q[i], 3'b110});
        end
        @(negedge CLK);
        start = hold;
        check($sformatf("frame_%02h_done", d), {k, j, tx_en, busy, done}, {SYM_J, 3'b001});
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check("idle", {k, j, tx_en, busy, done}, {SYM_J, 3'b000});
        end
    endtask

    initial begin
        logic [1:0] sym;
        int         idx;
        n_cmp   = 0;
        n_err   = 0;
        RST     = 1'b0;
        start   = 1'b1;
        data_in = 8'h5A;

        tbl[0] = '{8'h00, 8, SYM_K};
        tbl[1] = '{8'hA5, 8, SYM_K};
        tbl[2] = '{8'h3C, 8, SYM_K};
        tbl[3] = '{8'h01, 8, SYM_J};
`ifdef SYNC_TX_BIT_STUFF_EN
        tbl[4] = '{8'hFF, 9, SYM_J};
        tbl[5] = '{8'h7F, 9, SYM_K};
`else
        tbl[4] = '{8'hFF, 8, SYM_K};
        tbl[5] = '{8'h7F, 8, SYM_J};
`endif

        // Reset held with start high: line stays idle
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("reset_hold", {k, j, tx_en, busy, done}, {SYM_J, 3'b000});
        end
        start = 1'b0;
        #2 RST = 1'b1;
        idle_cycles(3);

        // Vector table: full frame against the model plus DATA length and final level
        foreach (tbl[t]) begin
            run_frame(tbl[t].data, -1, 1'b0);
            idx = int'(SYNC_LEN + tbl[t].len) - 1;
            sym = (idx < act_q.size()) ? act_q[idx] : 2'b11;
            check($sformatf("tbl_%02h_last_data", tbl[t].data), {sym, 3'b000}, {tbl[t].last, 3'b000});
            sym = (idx + 1 < act_q.size()) ? act_q[idx + 1] : 2'b11;
            check($sformatf("tbl_%02h_first_eop", tbl[t].data), {sym, 3'b000}, {SYM_SE0, 3'b000});
            idle_cycles(1);
        end

        // Start re-pulsed mid-DATA is ignored; start in the done cycle begins the next frame at once
        run_frame(8'h00, int'(SYNC_LEN) + 2, 1'b0);
        run_frame(8'hA5, -1, 1'b0);
        idle_cycles(2);

        // Start held high: back-to-back frames separated by the single done/idle cycle
        run_frame(8'hFF, -1, 1'b1);
        run_frame(8'h3C, -1, 1'b0);
        idle_cycles(2);

        // Reset mid-DATA: asynchronous return to idle, no done, then a clean frame
        start   = 1'b1;
        data_in = 8'hC3;
        @(negedge CLK);
        start = 1'b0;
        repeat (SYNC_LEN + 2) @(negedge CLK);
        check("pre_reset_in_data", {2'b00, tx_en, busy, done}, 5'b00110);
        RST = 1'b0;
        #1;
        check("reset_async", {k, j, tx_en, busy, done}, {SYM_J, 3'b000});
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("reset_mid_frame", {k, j, tx_en, busy, done}, {SYM_J, 3'b000});
        end
        RST = 1'b1;
        idle_cycles(3);
        run_frame(8'h00, -1, 1'b0);
        idle_cycles(1);

        // Random frames with random mid-frame start pulses, gaps and held starts
        for (int r = 0; r < 40; r++) begin
            logic [7:0] d;
            int         g;
            bit         h;
            d = 8'($urandom);
            g = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 22));
            h = ($urandom_range(0, 3) == 0);
            run_frame(d, g, h);
            if (!h) idle_cycles(int'($urandom_range(0, 3)));
        end
        start = 1'b0;
        @(negedge CLK);
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
